multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the instruction register, the PC and the register file across several cycles per instruction.
- It sits beside the existing combinational ALU-operation decoder and drives that decoder through o_aluOp.
- Supports lw, sw, R-type, I-type ALU, beq and jal. Memory accesses stall on a ready handshake.

---
 rtl/multicycle_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core.
// Sequences the shared ALU, unified memory port, IR, PC and register file.
// Supported: lw, sw, R-type, I-type ALU, beq, jal; illegal opcodes trap.
// Optional performance counters (o_cycles, o_instret) are built only when
// the macro MULTICYCLE_CONTROLLER_PERF_EN is defined; otherwise both read 0.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [6:0]        i_opcode,
  input  logic              i_zero,
  input  logic              i_memReady,
  output logic              o_memReq,
  output logic              o_memWrite,
  output logic              o_irWrite,
  output logic              o_pcWrite,
  output logic              o_regWrite,
  output logic              o_adrSrc,
  output logic [1:0]        o_aluSrcA,
  output logic [1:0]        o_aluSrcB,
  output logic [1:0]        o_aluOp,
  output logic [1:0]        o_resultSrc,
  output logic              o_trap,
  output logic [PERF_W-1:0] o_instret,
  output logic [PERF_W-1:0] o_cycles
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWRITE = 4'd4;
  localparam logic [3:0] MEMWB    = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The wait counter must be able to hold MEM_TIMEOUT itself.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Trap fires on the stall cycle that would bring the count up to MEM_TIMEOUT.
  localparam logic [CNT_W-1:0] WAIT_LIMIT =
    (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state;
  logic             stall;
  logic             timeout_hit;

  logic             mem_req;
  logic             mem_write;
  logic             ir_write;
  logic             pc_update;
  logic             branch;
  logic             reg_write;
  logic             adr_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       result_src;
  logic             trap;

  assign mem_state   = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign stall       = mem_state && !i_memReady;
  assign timeout_hit = (MEM_TIMEOUT != 0) && stall && (wait_cnt == WAIT_LIMIT);

  // Next-state selection; a ready handshake always wins over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (i_memReady)       state_next = DECODE;
        else if (timeout_hit) state_next = TRAP;
      end
      DECODE: begin
        case (i_opcode)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECR;
          OP_ITYPE:          state_next = EXECI;
          OP_BRANCH:         state_next = BEQ;
          OP_JAL:            state_next = JAL;
          default:           state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = i_opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (i_memReady)       state_next = MEMWB;
        else if (timeout_hit) state_next = TRAP;
      end
      MEMWRITE: begin
        if (i_memReady)       state_next = FETCH;
        else if (timeout_hit) state_next = TRAP;
      end
      MEMWB:    state_next = FETCH;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      JAL:      state_next = ALUWB;
      TRAP:     state_next = TRAP;
      default:  state_next = TRAP;
    endcase
  end

  // State register; reset restarts fetch from any state, including TRAP.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= FETCH;
    else          state <= state_next;
  end

  // Counts consecutive stalled memory cycles, saturating to avoid wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                wait_cnt <= '0;
    else if (stall) begin
      if (wait_cnt != {CNT_W{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
    end
    else                         wait_cnt <= '0;
  end

  // Moore control decode; only FETCH looks at ready to gate IR/PC loads.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    trap       = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = i_memReady;
        pc_update  = i_memReady;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      TRAP:     trap = 1'b1;
      default:  trap = 1'b1;
    endcase
  end

  // While reset is held every output is forced low so nothing is written.
  always_comb begin
    o_memReq    = i_rst_n & mem_req;
    o_memWrite  = i_rst_n & mem_write;
    o_irWrite   = i_rst_n & ir_write;
    o_pcWrite   = i_rst_n & (pc_update | (branch & i_zero));
    o_regWrite  = i_rst_n & reg_write;
    o_adrSrc    = i_rst_n & adr_src;
    o_aluSrcA   = i_rst_n ? alu_src_a  : 2'b00;
    o_aluSrcB   = i_rst_n ? alu_src_b  : 2'b00;
    o_aluOp     = i_rst_n ? alu_op     : 2'b00;
    o_resultSrc = i_rst_n ? result_src : 2'b00;
    o_trap      = i_rst_n & trap;
  end

`ifdef MULTICYCLE_CONTROLLER_PERF_EN
  logic              retire;
  logic [PERF_W-1:0] cycles_q;
  logic [PERF_W-1:0] instret_q;

  assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                  ((state == MEMWRITE) && i_memReady);

  // Free-running cycle count and retired-instruction count, both wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cycles_q  <= '0;
      instret_q <= '0;
    end
    else begin
      cycles_q <= cycles_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign o_cycles  = cycles_q;
  assign o_instret = instret_q;
`else
  assign o_cycles  = '0;
  assign o_instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized self-checking bench for the
// multicycle control FSM. Instructions are expanded into an expected
// per-cycle control trace (queue) from the instruction-level behaviour,
// then replayed against the DUT. Counter expectations follow
// MULTICYCLE_CONTROLLER_PERF_EN.
module tb_multicycle_controller;

  localparam int TIMEOUT = 4;
  localparam int PERF_W  = 32;
`ifdef MULTICYCLE_CONTROLLER_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [6:0]        opcode = 7'd0;
  logic              zero = 1'b0;
  logic              mem_ready = 1'b0;
  logic              mem_req, mem_write, ir_write, pc_write, reg_write, adr_src, trap;
  logic [1:0]        alu_src_a, alu_src_b, alu_op, result_src;
  logic [PERF_W-1:0] instret, cycles;

  int checks = 0;
  int errors = 0;
  int model_cycles = 0;
  int model_instret = 0;
  bit counters_valid = 1'b0;

  typedef struct {
    logic [14:0] ctl;
    logic [6:0]  op;
    bit          ready;
    bit          zero;
    bit          rst;
    bit          retire;
    string       tag;
  } step_t;

  step_t trace[$];

  logic [14:0] c_fetch_wait, c_fetch, c_decode, c_memadr, c_memread, c_memwrite;
  logic [14:0] c_memwb, c_execr, c_execi, c_aluwb, c_jal, c_trap;

  multicycle_controller #(.MEM_TIMEOUT(TIMEOUT), .PERF_W(PERF_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero),
    .i_memReady(mem_ready), .o_memReq(mem_req), .o_memWrite(mem_write),
    .o_irWrite(ir_write), .o_pcWrite(pc_write), .o_regWrite(reg_write),
    .o_adrSrc(adr_src), .o_aluSrcA(alu_src_a), .o_aluSrcB(alu_src_b),
    .o_aluOp(alu_op), .o_resultSrc(result_src), .o_trap(trap),
    .o_instret(instret), .o_cycles(cycles)
  );

  always #5 clk = ~clk;

  // Packs one cycle's worth of control outputs into a comparable vector.
  function automatic logic [14:0] mk(input bit mr, input bit mw, input bit ir,
                                     input bit pw, input bit rw, input bit as,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] ao, input logic [1:0] rs,
                                     input bit tr);
    return {mr, mw, ir, pw, rw, as, sa, sb, ao, rs, tr};
  endfunction

  function automatic bit rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void pushStep(input logic [14:0] c, input logic [6:0] op,
                                   input bit rdy, input bit z, input bit rs,
                                   input bit ret, input string tag);
    step_t s;
    s.ctl = c; s.op = op; s.ready = rdy; s.zero = z;
    s.rst = rs; s.retire = ret; s.tag = tag;
    trace.push_back(s);
  endfunction

  function automatic void pushReset(input logic [6:0] op);
    pushStep(15'd0, op, rnd1(), rnd1(), 1'b1, 1'b0, "reset");
  endfunction

  function automatic void pushTrap(input logic [6:0] op, input int n);
    for (int k = 0; k < n; k++) pushStep(c_trap, op, rnd1(), rnd1(), 1'b0, 1'b0, "trap");
    pushReset(op);
  endfunction

  // Stalled memory cycles; the TIMEOUT-th consecutive stall lands in TRAP.
  function automatic bit pushWait(input logic [14:0] c, input logic [6:0] op,
                                  input int n, input string tag);
    for (int k = 0; k < n && k < TIMEOUT; k++)
      pushStep(c, op, 1'b0, rnd1(), 1'b0, 1'b0, tag);
    if (n >= TIMEOUT) begin
      pushTrap(op, 3);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expands one instruction into its expected cycle-by-cycle control trace.
  function automatic void buildInstr(input logic [6:0] op, input int fst,
                                     input int mst, input bit bz, input int trap_len);
    if (pushWait(c_fetch_wait, op, fst, "fetch_wait")) return;
    pushStep(c_fetch, op, 1'b1, rnd1(), 1'b0, 1'b0, "fetch");
    pushStep(c_decode, op, rnd1(), rnd1(), 1'b0, 1'b0, "decode");
    case (op)
      LW: begin
        pushStep(c_memadr, op, rnd1(), rnd1(), 1'b0, 1'b0, "memadr");
        if (pushWait(c_memread, op, mst, "memread_wait")) return;
        pushStep(c_memread, op, 1'b1, rnd1(), 1'b0, 1'b0, "memread");
        pushStep(c_memwb, op, rnd1(), rnd1(), 1'b0, 1'b1, "memwb");
      end
      SW: begin
        pushStep(c_memadr, op, rnd1(), rnd1(), 1'b0, 1'b0, "memadr");
        if (pushWait(c_memwrite, op, mst, "memwrite_wait")) return;
        pushStep(c_memwrite, op, 1'b1, rnd1(), 1'b0, 1'b1, "memwrite");
      end
      RT: begin
        pushStep(c_execr, op, rnd1(), rnd1(), 1'b0, 1'b0, "execr");
        pushStep(c_aluwb, op, rnd1(), rnd1(), 1'b0, 1'b1, "aluwb");
      end
      IT: begin
        pushStep(c_execi, op, rnd1(), rnd1(), 1'b0, 1'b0, "execi");
        pushStep(c_aluwb, op, rnd1(), rnd1(), 1'b0, 1'b1, "aluwb");
      end
      BR: pushStep(mk(0,0,0,bz,0,0,2'b10,2'b00,2'b01,2'b00,0), op, rnd1(), bz,
                   1'b0, 1'b1, "beq");
      JL: begin
        pushStep(c_jal, op, rnd1(), rnd1(), 1'b0, 1'b0, "jal");
        pushStep(c_aluwb, op, rnd1(), rnd1(), 1'b0, 1'b1, "aluwb");
      end
      default: pushTrap(op, trap_len);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle's inputs on the falling edge and checks just after.
  task automatic applyStimulus(input step_t s);
    @(negedge clk);
    rst_n     = !s.rst;
    opcode    = s.op;
    mem_ready = s.ready;
    zero      = s.zero;
    #1;
    checkOutput(s.tag, 32'({mem_req, mem_write, ir_write, pc_write, reg_write, adr_src,
                            alu_src_a, alu_src_b, alu_op, result_src, trap}), 32'(s.ctl));
    if (!s.rst && counters_valid) begin
      checkOutput("cycles", 32'(cycles), PERF_ON ? 32'(model_cycles) : 32'd0);
      checkOutput("instret", 32'(instret), PERF_ON ? 32'(model_instret) : 32'd0);
    end
    if (s.rst) begin
      model_cycles   = 0;
      model_instret  = 0;
      counters_valid = 1'b1;
    end
    else begin
      model_cycles++;
      if (s.retire) model_instret++;
    end
  endtask

  task automatic runTrace();
    step_t s;
    while (trace.size() > 0) begin
      s = trace.pop_front();
      applyStimulus(s);
    end
  endtask

  initial begin
    logic [6:0] op;
    int         pick;
    c_fetch_wait = mk(1,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
    c_fetch      = mk(1,0,1,1,0,0,2'b00,2'b10,2'b00,2'b10,0);
    c_decode     = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
    c_memadr     = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0);
    c_memread    = mk(1,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
    c_memwrite   = mk(1,1,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
    c_memwb      = mk(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b01,0);
    c_execr      = mk(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0);
    c_execi      = mk(0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00,0);
    c_aluwb      = mk(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0);
    c_jal        = mk(0,0,0,1,0,0,2'b01,2'b10,2'b00,2'b00,0);
    c_trap       = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1);

    pushReset(LW);
    pushReset(LW);
    runTrace();

    buildInstr(LW, 0, 0, 1'b0, 3);
    buildInstr(SW, 0, 3, 1'b0, 3);
    buildInstr(BR, 0, 0, 1'b1, 3);
    buildInstr(BR, 0, 0, 1'b0, 3);
    buildInstr(7'b1111111, 0, 0, 1'b0, 10);
    buildInstr(RT, 4, 0, 1'b0, 3);
    buildInstr(IT, 3, 0, 1'b0, 3);
    buildInstr(LW, 0, 4, 1'b0, 3);
    buildInstr(SW, 2, 4, 1'b0, 3);
    buildInstr(JL, 0, 0, 1'b0, 3);
    runTrace();

    pushStep(c_fetch, RT, 1'b1, 1'b0, 1'b0, 1'b0, "fetch");
    pushStep(c_decode, RT, 1'b0, 1'b0, 1'b0, 1'b0, "decode");
    pushStep(15'd0, RT, 1'b1, 1'b1, 1'b1, 1'b0, "reset_in_execr");
    buildInstr(IT, 0, 0, 1'b0, 3);
    runTrace();

    for (int n = 0; n < 120; n++) begin
      pick = $urandom_range(0, 12);
      case (pick)
        0, 1:    op = LW;
        2, 3:    op = SW;
        4, 5:    op = RT;
        6, 7:    op = IT;
        8, 9:    op = BR;
        10, 11:  op = JL;
        default: begin
          op = 7'($urandom_range(0, 127));
          if (op == LW || op == SW || op == RT || op == IT || op == BR || op == JL)
            op = 7'd0;
        end
      endcase
      buildInstr(op, $urandom_range(0, 3), $urandom_range(0, 3), rnd1(),
                 $urandom_range(1, 4));
      runTrace();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
